// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller:
// state encoding, opcode/func constants, ALU codes and datapath mux-select
// encodings. Imported by multicycle_ctrl and mc_alu_dec.
package cpu_pkg;

  localparam int ST_W_DEF  = 4;
  localparam int ALU_W_DEF = 3;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_JR       = 4'd12,
    ST_JAL      = 4'd13,
    ST_ILLEGAL  = 4'd14
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type func codes (IR[5:0])
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_LUI = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Datapath mux selects
  localparam logic [1:0] SRC_A_PC      = 2'd0;
  localparam logic [1:0] SRC_A_RS      = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT   = 2'd2;
  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;
  localparam logic [1:0] REG_DST_RT    = 2'd0;
  localparam logic [1:0] REG_DST_RD    = 2'd1;
  localparam logic [1:0] REG_DST_RA    = 2'd2;
  localparam logic [1:0] M2R_ALUOUT    = 2'd0;
  localparam logic [1:0] M2R_MDR       = 2'd1;
  localparam logic [1:0] M2R_PC        = 2'd2;
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational instruction decoder for the multi-cycle controller.
// Ports:
//   opcode, func   : IR opcode and func fields
//   alu_ctrl       : ALU operation for R-type (by func) or I-type (by opcode)
//   sign_or_zero   : 1 = zero-extend the immediate (andi/ori)
//   legal          : instruction belongs to the supported subset
module mc_alu_dec
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [2:0] alu_ctrl,
  output logic       sign_or_zero,
  output logic       legal
);

  // Opcode/func lookup; anything not listed is illegal.
  always_comb begin
    alu_ctrl     = ALU_ADD;
    sign_or_zero = 1'b0;
    legal        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin legal = 1'b1; alu_ctrl = ALU_ADD; end
          FN_SUB:  begin legal = 1'b1; alu_ctrl = ALU_SUB; end
          FN_AND:  begin legal = 1'b1; alu_ctrl = ALU_AND; end
          FN_OR:   begin legal = 1'b1; alu_ctrl = ALU_OR;  end
          FN_SLT:  begin legal = 1'b1; alu_ctrl = ALU_SLT; end
          FN_SRL:  begin legal = 1'b1; alu_ctrl = ALU_SRL; end
          FN_JR:   begin legal = 1'b1; end
          default: begin legal = 1'b0; end
        endcase
      end
      OP_ADDI: begin legal = 1'b1; alu_ctrl = ALU_ADD; end
      OP_ANDI: begin legal = 1'b1; alu_ctrl = ALU_AND; sign_or_zero = 1'b1; end
      OP_ORI:  begin legal = 1'b1; alu_ctrl = ALU_OR;  sign_or_zero = 1'b1; end
      OP_SLTI: begin legal = 1'b1; alu_ctrl = ALU_SLT; end
      OP_LUI:  begin legal = 1'b1; alu_ctrl = ALU_LUI; end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: begin
        legal = 1'b1;
      end
      default: begin legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-subset CPU. Moore FSM driving PC/IR/
// register-file/ALU/memory enables and mux selects; the branch pc_we also
// depends on the current-cycle ALU zero flag.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   opcode, func, zero    : IR fields and ALU zero flag
//   mem_ready             : unified memory completes access this cycle
//   pc_we, ir_we, reg_we  : write enables
//   iord, mem_req, mem_we : memory address select / request / write
//   alu_src_a/b, alu_ctrl, sign_or_zero : ALU operand and op control
//   reg_dst, mem2reg, pc_src : register-file and PC mux selects
//   instr_done            : pulse in the final cycle of each instruction
//   illegal               : sticky unsupported-instruction flag
//   state                 : current state (debug)
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int ST_W  = ST_W_DEF,
  parameter int ALU_W = ALU_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic             sign_or_zero,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem2reg,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal,
  output logic [ST_W-1:0]  state
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [2:0] alu_op;
  logic [2:0] dec_alu_ctrl;
  logic       dec_soz;
  logic       dec_legal;

  mc_alu_dec u_alu_dec (
    .opcode       (opcode),
    .func         (func),
    .alu_ctrl     (dec_alu_ctrl),
    .sign_or_zero (dec_soz),
    .legal        (dec_legal)
  );

  // State and sticky illegal flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore outputs. During reset every enable and select
  // stays at its zero default so an interrupted access issues no write.
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    iord         = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_RT;
    alu_op       = ALU_ADD;
    sign_or_zero = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = REG_DST_RT;
    mem2reg      = M2R_ALUOUT;
    pc_src       = PC_SRC_ALU;
    instr_done   = 1'b0;
    if (reset) begin
      state_d   = ST_FETCH;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = SRC_B_FOUR;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_DECODE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_DECODE: begin
          // Branch target PC + (sext imm << 2) lands in ALUOut.
          alu_src_b = SRC_B_IMM_SH2;
          if (!dec_legal) begin
            state_d   = ST_ILLEGAL;
            illegal_d = 1'b1;
          end else begin
            case (opcode)
              OP_RTYPE: state_d = (func == FN_JR) ? ST_JR : ST_EXEC_R;
              OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = ST_EXEC_I;
              OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
              OP_BEQ, OP_BNE: state_d = ST_BRANCH;
              OP_J:           state_d = ST_JUMP;
              OP_JAL:         state_d = ST_JAL;
              default: begin
                state_d   = ST_ILLEGAL;
                illegal_d = 1'b1;
              end
            endcase
          end
        end
        ST_EXEC_R: begin
          alu_op    = dec_alu_ctrl;
          alu_src_b = SRC_B_RT;
          alu_src_a = (func == FN_SRL) ? SRC_A_SHAMT : SRC_A_RS;
          state_d   = ST_WB_R;
        end
        ST_WB_R: begin
          reg_we     = 1'b1;
          reg_dst    = REG_DST_RD;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_EXEC_I: begin
          alu_src_a    = SRC_A_RS;
          alu_src_b    = SRC_B_IMM;
          alu_op       = dec_alu_ctrl;
          sign_or_zero = dec_soz;
          state_d      = ST_WB_I;
        end
        ST_WB_I: begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_MEM_ADDR: begin
          alu_src_a = SRC_A_RS;
          alu_src_b = SRC_B_IMM;
          state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          state_d = mem_ready ? ST_WB_MEM : ST_MEM_RD;
        end
        ST_WB_MEM: begin
          reg_we     = 1'b1;
          mem2reg    = M2R_MDR;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
          state_d    = mem_ready ? ST_FETCH : ST_MEM_WR;
        end
        ST_BRANCH: begin
          alu_src_a  = SRC_A_RS;
          alu_src_b  = SRC_B_RT;
          alu_op     = ALU_SUB;
          pc_src     = PC_SRC_ALUOUT;
          pc_we      = (opcode == OP_BEQ) ? zero : !zero;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_JUMP: begin
          pc_src     = PC_SRC_JUMP;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_JR: begin
          pc_src     = PC_SRC_RS;
          pc_we      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_JAL: begin
          // PC already holds PC+4 from FETCH; it is written to $31 here.
          pc_src     = PC_SRC_JUMP;
          pc_we      = 1'b1;
          reg_we     = 1'b1;
          reg_dst    = REG_DST_RA;
          mem2reg    = M2R_PC;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
        ST_ILLEGAL: begin
          illegal_d = 1'b1;
          state_d   = ST_ILLEGAL;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  assign alu_ctrl = ALU_W'(alu_op);
  assign illegal  = illegal_q;
  assign state    = ST_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, func;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, iord, mem_req, mem_we, sign_or_zero, reg_we;
  logic       instr_done, illegal;
  logic [1:0] alu_src_a, alu_src_b, reg_dst, mem2reg, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .iord(iord),
    .mem_req(mem_req), .mem_we(mem_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .sign_or_zero(sign_or_zero),
    .reg_we(reg_we), .reg_dst(reg_dst), .mem2reg(mem2reg), .pc_src(pc_src),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow input changes before sampling.
  task automatic settle();
    #2;
  endtask

  // FETCH and DECODE with no memory wait; leaves the bench in cycle 3.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    opcode = op; func = fn; mem_ready = 1'b1;
    settle();
    check_eq("fetch_state", state, 4'd0);
    check_eq("fetch_irwe", ir_we, 1'b1);
    cyc();
    settle();
    check_eq("decode_state", state, 4'd1);
    check_eq("decode_srcb", alu_src_b, 2'd3);
    cyc();
  endtask

  task automatic run_branch(input logic [5:0] op, input logic z, input logic exp_we, input string tag);
    fetch_decode(op, 6'h00);
    zero = z;
    settle();
    check_eq({tag, "_pcwe"}, pc_we, exp_we);
    check_eq({tag, "_pcsrc"}, pc_src, 2'd1);
    check_eq({tag, "_alu"}, alu_ctrl, 3'b001);
    check_eq({tag, "_done"}, instr_done, 1'b1);
    cyc();
    zero = 1'b0;
  endtask

  initial begin
    int ir_cnt, early_we, early_done, bad;
    reset = 1'b1; opcode = 6'h00; func = 6'h20; zero = 1'b0; mem_ready = 1'b1;
    settle();
    check_eq("rst_memreq", mem_req, 1'b0);
    check_eq("rst_srcb", alu_src_b, 2'd0);
    cyc();
    reset = 1'b0;
    settle();
    check_eq("rst_state", state, 4'd0);
    check_eq("rst_illegal", illegal, 1'b0);
    check_eq("fetch_memreq", mem_req, 1'b1);
    check_eq("fetch_srcb", alu_src_b, 2'd1);

    // add: 4 cycles, single write and done pulse in cycle 4
    fetch_decode(6'h00, 6'h20);
    settle();
    check_eq("add_c3_state", state, 4'd2);
    check_eq("add_c3_srca", alu_src_a, 2'd1);
    check_eq("add_c3_regwe", reg_we, 1'b0);
    check_eq("add_c3_done", instr_done, 1'b0);
    cyc();
    settle();
    check_eq("add_c4_regwe", reg_we, 1'b1);
    check_eq("add_c4_regdst", reg_dst, 2'd1);
    check_eq("add_c4_done", instr_done, 1'b1);
    cyc();
    settle();
    check_eq("add_after_done", instr_done, 1'b0);
    check_eq("add_after_state", state, 4'd0);

    // lw with 2 fetch waits and 3 read waits: 10 cycles
    opcode = 6'h23; func = 6'h00;
    ir_cnt = 0; early_we = 0; early_done = 0;
    for (int c = 1; c <= 10; c++) begin
      mem_ready = (c == 1 || c == 2 || c == 6 || c == 7 || c == 8) ? 1'b0 : 1'b1;
      settle();
      ir_cnt += int'(ir_we);
      if (!mem_ready) begin
        check_eq($sformatf("lw_wait_req_c%0d", c), mem_req, 1'b1);
        check_eq($sformatf("lw_wait_pcwe_c%0d", c), pc_we, 1'b0);
      end
      if (c >= 6 && c <= 9) check_eq($sformatf("lw_iord_c%0d", c), iord, 1'b1);
      if (c == 10) begin
        check_eq("lw_last_regwe", reg_we, 1'b1);
        check_eq("lw_last_m2r", mem2reg, 2'd1);
        check_eq("lw_last_done", instr_done, 1'b1);
      end else begin
        early_we += int'(reg_we);
        early_done += int'(instr_done);
      end
      cyc();
    end
    mem_ready = 1'b1;
    settle();
    check_eq("lw_ir_pulses", ir_cnt, 1);
    check_eq("lw_early_regwe", early_we, 0);
    check_eq("lw_early_done", early_done, 0);
    check_eq("lw_end_state", state, 4'd0);

    // branches
    run_branch(6'h04, 1'b1, 1'b1, "beq_z1");
    run_branch(6'h04, 1'b0, 1'b0, "beq_z0");
    run_branch(6'h05, 1'b0, 1'b1, "bne_z0");

    // jal
    fetch_decode(6'h03, 6'h00);
    settle();
    check_eq("jal_pcwe", pc_we, 1'b1);
    check_eq("jal_pcsrc", pc_src, 2'd2);
    check_eq("jal_regwe", reg_we, 1'b1);
    check_eq("jal_regdst", reg_dst, 2'd2);
    check_eq("jal_m2r", mem2reg, 2'd2);
    check_eq("jal_done", instr_done, 1'b1);
    cyc();

    // srl
    fetch_decode(6'h00, 6'h02);
    settle();
    check_eq("srl_srca", alu_src_a, 2'd2);
    check_eq("srl_srcb", alu_src_b, 2'd0);
    check_eq("srl_alu", alu_ctrl, 3'b101);
    cyc();
    cyc();

    // ori: zero-extended OR, rt write
    fetch_decode(6'h0D, 6'h00);
    settle();
    check_eq("ori_alu", alu_ctrl, 3'b011);
    check_eq("ori_soz", sign_or_zero, 1'b1);
    check_eq("ori_srcb", alu_src_b, 2'd2);
    cyc();
    settle();
    check_eq("ori_regwe", reg_we, 1'b1);
    check_eq("ori_regdst", reg_dst, 2'd0);
    cyc();

    // jr
    fetch_decode(6'h00, 6'h08);
    settle();
    check_eq("jr_pcsrc", pc_src, 2'd3);
    check_eq("jr_pcwe", pc_we, 1'b1);
    cyc();

    // sw normal completion: done in the mem_ready cycle
    fetch_decode(6'h2B, 6'h00);
    cyc();
    settle();
    check_eq("sw_memwe", mem_we, 1'b1);
    check_eq("sw_done", instr_done, 1'b1);
    cyc();

    // illegal opcode 0x3F
    fetch_decode(6'h3F, 6'h00);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      settle();
      if (illegal !== 1'b1 || pc_we || ir_we || mem_req || mem_we || reg_we || instr_done)
        bad++;
      cyc();
    end
    check_eq("ill_bad_cycles", bad, 0);
    check_eq("ill_state", state, 4'd14);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    check_eq("ill_rst_state", state, 4'd0);
    check_eq("ill_rst_flag", illegal, 1'b0);

    // sw aborted by reset during MEM_WR wait
    fetch_decode(6'h2B, 6'h00);
    cyc();
    mem_ready = 1'b0;
    settle();
    check_eq("swab_memwe", mem_we, 1'b1);
    check_eq("swab_wait_done", instr_done, 1'b0);
    cyc();
    reset = 1'b1;
    settle();
    check_eq("swab_rst_memwe", mem_we, 1'b0);
    check_eq("swab_rst_done", instr_done, 1'b0);
    cyc();
    reset = 1'b0;
    settle();
    check_eq("swab_state", state, 4'd0);
    check_eq("swab_memwe2", mem_we, 1'b0);
    check_eq("swab_regwe", reg_we, 1'b0);
    check_eq("swab_done2", instr_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
